// File: rtl/zeroheti_dmem_arbiter.sv
// zeroheti_dmem_arbiter
// Shares the single-port data SRAM between NumReq OBI-style requesters.
// One request is granted per cycle in round-robin order, its address is
// range-checked against the dmem window, and the response (one cycle later)
// is routed back to the requester that was granted.
//
// Ports
//   clk_i, rst_i      clock (rising edge), synchronous active-high reset
//   req_i/gnt_o       per-requester request valid / combinational grant
//   addr_i, we_i, be_i, wdata_i
//                     per-requester byte address, write enable, byte enables,
//                     write data (packed, requester 0 in the low slice)
//   rvalid_o          per-requester response valid (one-hot or zero)
//   rdata_o, err_o    shared response data / error, qualified by rvalid_o
//   mem_*             SRAM macro interface; mem_rdata_i valid one cycle
//                     after mem_req_o
module zeroheti_dmem_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter logic [31:0] BaseAddr  = 32'h0002_0000,
    parameter int unsigned SizeBytes = 4096,
    localparam int unsigned AW       = $clog2(SizeBytes / 4),
    localparam int unsigned IDW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_i,
    output logic [NumReq-1:0]      gnt_o,
    input  logic [NumReq*32-1:0]   addr_i,
    input  logic [NumReq-1:0]      we_i,
    input  logic [NumReq*4-1:0]    be_i,
    input  logic [NumReq*32-1:0]   wdata_i,
    output logic [NumReq-1:0]      rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AW-1:0]          mem_addr_o,
    output logic [3:0]             mem_be_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_err_q;

    logic [IDW-1:0] win;
    logic           any_gnt;
    logic [31:0]    sel_addr;
    logic [32:0]    offset;
    logic           in_range;

    // Round-robin scan starting at rr_ptr; with no request, win stays at
    // rr_ptr so the mem_* outputs are driven from a defined requester.
    always_comb begin
        int unsigned idx;
        any_gnt = 1'b0;
        win     = rr_ptr_q;
        idx     = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(rr_ptr_q) + k) % NumReq;
            if (!any_gnt && req_i[idx]) begin
                any_gnt = 1'b1;
                win     = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any_gnt) begin
            gnt_o[win] = 1'b1;
        end
    end

    // 33-bit subtraction so addresses below BaseAddr cannot wrap into range.
    always_comb begin
        sel_addr = addr_i[32*win +: 32];
        offset   = {1'b0, sel_addr} - {1'b0, BaseAddr};
        in_range = (sel_addr >= BaseAddr) && (offset < 33'(SizeBytes));
    end

    always_comb begin
        mem_req_o   = any_gnt & in_range;
        mem_we_o    = we_i[win];
        mem_addr_o  = offset[AW+1:2];
        mem_be_o    = be_i[4*win +: 4];
        mem_wdata_o = wdata_i[32*win +: 32];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        state_d  = IDLE;
        if (any_gnt) begin
            rr_ptr_d = (win == IDW'(NumReq - 1)) ? '0 : win + 1'b1;
            state_d  = RESP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= win;
            rsp_err_q <= ~in_range;
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (state_q == RESP) begin
            rvalid_o[rsp_id_q] = 1'b1;
        end
        err_o   = (state_q == RESP) & rsp_err_q;
        rdata_o = ((state_q == RESP) && !rsp_err_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_zeroheti_dmem_arbiter.sv
module tb_zeroheti_dmem_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam logic [31:0] BASE  = 32'h0002_0000;
    localparam int unsigned SIZE  = 4096;
    localparam int unsigned AWT   = 10;
    localparam int unsigned WORDS = SIZE / 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_i, gnt_o, we_i, rvalid_o;
    logic [NREQ*32-1:0] addr_i, wdata_i;
    logic [NREQ*4-1:0] be_i;
    logic [31:0]       rdata_o, mem_wdata_o, mem_rdata_i;
    logic              err_o, mem_req_o, mem_we_o;
    logic [AWT-1:0]    mem_addr_o;
    logic [3:0]        mem_be_o;

    logic [31:0] t_addr  [NREQ];
    logic [31:0] t_wdata [NREQ];
    logic [3:0]  t_be    [NREQ];
    logic        t_we    [NREQ];

    assign addr_i  = {t_addr[1], t_addr[0]};
    assign wdata_i = {t_wdata[1], t_wdata[0]};
    assign be_i    = {t_be[1], t_be[0]};
    assign we_i    = {t_we[1], t_we[0]};

    always #5 clk = ~clk;

    zeroheti_dmem_arbiter #(
        .NumReq   (NREQ),
        .BaseAddr (BASE),
        .SizeBytes(SIZE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_be_o   (mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // SRAM macro stand-in: one-cycle read latency, byte-masked writes.
    logic [31:0] sram [WORDS];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // Reference model state, kept independently of the SRAM stand-in.
    typedef struct {
        logic [1:0]  rv;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [WORDS];
    int unsigned ref_rr;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    function automatic bit in_rng(logic [31:0] a);
        longint la, off;
        la  = longint'(a);
        off = la - longint'(BASE);
        return (la >= longint'(BASE)) && (off < longint'(SIZE));
    endfunction

    task automatic model_arb(input logic [1:0] r, output logic [1:0] eg, output int w);
        eg = '0;
        w  = -1;
        for (int k = 0; k < 2; k++) begin
            int i;
            i = int'((ref_rr + k) % 2);
            if (w < 0 && r[i]) w = i;
        end
        if (w >= 0) begin
            eg[w]  = 1'b1;
            ref_rr = (w + 1) % 2;
        end
    endtask

    task automatic push_exp(input int w);
        exp_t e;
        int   idx;
        e.rv = '0; e.err = 1'b0; e.chk = 1'b1; e.data = '0;
        if (w >= 0) begin
            e.rv[w] = 1'b1;
            if (!in_rng(t_addr[w])) begin
                e.err = 1'b1;
            end else begin
                idx = int'((t_addr[w] - BASE) >> 2);
                if (t_we[w]) begin
                    e.chk = 1'b0;
                    for (int b = 0; b < 4; b++)
                        if (t_be[w][b]) ref_mem[idx][8*b +: 8] = t_wdata[w][8*b +: 8];
                end else begin
                    e.data = ref_mem[idx];
                end
            end
        end
        sb.push_back(e);
    endtask

    // Drive req, settle, run the model and queue the expected response.
    task automatic issue(input logic [1:0] r, output logic [1:0] eg, output int w);
        req_i = r;
        #1;
        model_arb(r, eg, w);
        push_exp(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Response scoreboard: one pop per cycle, idle expected when empty.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            exp_t e;
            if (sb.size() == 0) begin
                e.rv = '0; e.err = 1'b0; e.chk = 1'b1; e.data = '0;
            end else begin
                e = sb.pop_front();
            end
            checks++;
            if (rvalid_o !== e.rv) begin
                errors++;
                $display("FAIL rvalid @%0t: got %b expected %b", $time, rvalid_o, e.rv);
            end
            checks++;
            if (err_o !== e.err) begin
                errors++;
                $display("FAIL err @%0t: got %b expected %b", $time, err_o, e.err);
            end
            if (e.chk) begin
                checks++;
                if (rdata_o !== e.data) begin
                    errors++;
                    $display("FAIL rdata @%0t: got %h expected %h", $time, rdata_o, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        push_exp(-1);
        tick();
        rst_i  = 1'b0;
        ref_rr = 0;
    endtask

    task automatic test_reset();
        logic [1:0] eg;
        int w;
        rst_i = 1'b1;
        req_i = '0;
        tick();
        tick();
        sb.delete();
        ref_rr = 0;
        mon_en = 1'b1;
        checks++;
        if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid_o); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++;
        if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
        rst_i = 1'b0;
        issue(2'b00, eg, w);
        checks++;
        if (gnt_o !== eg) begin errors++; $display("FAIL idle_gnt: got %b expected %b", gnt_o, eg); end
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b expected 0", mem_req_o); end
        tick();
    endtask

    task automatic test_write_read();
        logic [1:0] eg;
        int w;
        t_addr[0] = 32'h0002_0010; t_we[0] = 1'b1; t_be[0] = 4'hF; t_wdata[0] = 32'hDEAD_BEEF;
        issue(2'b01, eg, w);
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", gnt_o); end
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
            errors++; $display("FAIL wr_mem_req_we: got %b%b expected 11", mem_req_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== 10'd4) begin errors++; $display("FAIL wr_mem_addr: got %0d expected 4", mem_addr_o); end
        checks++;
        if (mem_wdata_o !== 32'hDEAD_BEEF || mem_be_o !== 4'hF) begin
            errors++; $display("FAIL wr_mem_data: got %h/%h expected deadbeef/f", mem_wdata_o, mem_be_o);
        end
        tick();
        req_i = '0;
        t_addr[1] = 32'h0002_0010; t_we[1] = 1'b0; t_be[1] = 4'hF; t_wdata[1] = 32'h0;
        issue(2'b10, eg, w);
        checks++;
        if (gnt_o !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b expected 10", gnt_o); end
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 10'd4) begin
            errors++; $display("FAIL rd_mem: got req=%b we=%b addr=%0d expected 1/0/4", mem_req_o, mem_we_o, mem_addr_o);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        logic [1:0] want [4];
        int w;
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        do_reset();
        t_addr[0] = 32'h0002_0010; t_we[0] = 1'b0;
        t_addr[1] = 32'h0002_0014; t_we[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(2'b11, eg, w);
            checks++;
            if (gnt_o !== want[i]) begin
                errors++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, gnt_o, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        logic        inr   [4];
        logic [1:0]  eg;
        int w;
        addrs[0] = 32'h0001_FFFC; inr[0] = 1'b0;
        addrs[1] = BASE + SIZE;   inr[1] = 1'b0;
        addrs[2] = BASE + SIZE - 4; inr[2] = 1'b1;
        addrs[3] = 32'hFFFF_FFFC; inr[3] = 1'b0;
        req_i = '0;
        for (int i = 0; i < 4; i++) begin
            t_addr[i % 2] = addrs[i]; t_we[i % 2] = (i == 1); t_be[i % 2] = 4'hF;
            t_wdata[i % 2] = 32'h5555_AAAA;
            issue(2'b01 << (i % 2), eg, w);
            checks++;
            if (gnt_o !== eg || w != (i % 2)) begin
                errors++; $display("FAIL oor_gnt[%0d]: got %b expected %b", i, gnt_o, eg);
            end
            checks++;
            if (mem_req_o !== inr[i]) begin
                errors++; $display("FAIL oor_mem_req[%0d]: got %b expected %b", i, mem_req_o, inr[i]);
            end
            if (inr[i]) begin
                checks++;
                if (mem_addr_o !== 10'd1023) begin
                    errors++; $display("FAIL top_word_addr: got %0d expected 1023", mem_addr_o);
                end
            end
            tick();
            req_i = '0;
        end
    endtask

    task automatic test_byte_write();
        logic [1:0] eg;
        int w;
        t_addr[0] = 32'h0002_0040; t_we[0] = 1'b1; t_be[0] = 4'hF; t_wdata[0] = 32'h1122_3344;
        issue(2'b01, eg, w); tick();
        t_be[0] = 4'h2; t_wdata[0] = 32'h0000_AB00;
        issue(2'b01, eg, w);
        checks++;
        if (mem_be_o !== 4'h2) begin errors++; $display("FAIL byte_be: got %h expected 2", mem_be_o); end
        tick();
        t_be[0] = 4'h0; t_wdata[0] = 32'hFFFF_FFFF;
        issue(2'b01, eg, w);
        checks++;
        if (mem_be_o !== 4'h0 || mem_req_o !== 1'b1) begin
            errors++; $display("FAIL zero_be: got be=%h req=%b expected 0/1", mem_be_o, mem_req_o);
        end
        tick();
        t_we[0] = 1'b0; t_be[0] = 4'hF; t_addr[0] = 32'h0002_0043;
        issue(2'b01, eg, w);
        checks++;
        if (ref_mem[16] !== 32'h1122_AB44) begin
            errors++; $display("FAIL byte_model: got %h expected 1122ab44", ref_mem[16]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] eg;
        int w;
        t_addr[0] = 32'h0002_0010; t_we[0] = 1'b0;
        t_addr[1] = 32'h0002_0014; t_we[1] = 1'b0;
        issue(2'b01, eg, w);
        tick();
        rst_i = 1'b1;
        req_i = 2'b11;
        push_exp(-1);
        tick();
        rst_i  = 1'b0;
        ref_rr = 0;
        issue(2'b11, eg, w);
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL post_reset_gnt: got %b expected 01", gnt_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg;
        int w;
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                t_addr[r]  = ($urandom_range(0, 7) == 0) ? 32'h0003_0000
                                                         : BASE + 4 * $urandom_range(0, 7);
                t_we[r]    = 1'($urandom_range(0, 1));
                t_be[r]    = 4'($urandom_range(0, 15));
                t_wdata[r] = $urandom;
            end
            issue(2'($urandom_range(0, 3)), eg, w);
            checks++;
            if (gnt_o !== eg) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, gnt_o, eg); end
            checks++;
            if (mem_req_o !== (w >= 0 && in_rng(t_addr[(w >= 0) ? w : 0]))) begin
                errors++; $display("FAIL b2b_mem_req[%0d]: got %b", i, mem_req_o);
            end
            tick();
        end
        req_i = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_rdata_i = '0;
        req_i = '0;
        for (int r = 0; r < 2; r++) begin
            t_addr[r] = BASE; t_we[r] = 1'b0; t_be[r] = 4'hF; t_wdata[r] = '0;
        end
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_byte_write();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
